// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the multi-cycle PC sequencer: FSM state codes,
// the IR reset instruction and the PC alignment check.
package pc_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSN_DEF = 32'h0000_0013;

  function automatic logic pc_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction- and data-memory handshake bundle seen by the PC sequencer.
interface pc_sequencer_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_ready;

  modport master (
    output imem_req, imem_addr, dmem_req,
    input  imem_valid, imem_rdata, dmem_ready
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req,
    output imem_valid, imem_rdata, dmem_ready
  );

endinterface

// File: rtl/pc_sequencer.sv
// Multi-cycle control FSM owning PC and IR: fetch, decode, execute, memory,
// writeback, committing npc at writeback and halting on illegal/misaligned flow.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN    = NOP_INSN_DEF,
  parameter logic [31:0] RETIRE_INIT = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic [31:0]           npc,
  input  logic                  is_mem,
  input  logic                  wb_en,
  input  logic                  illegal,
  pc_sequencer_if.master        mem,
  output logic [31:0]           ir,
  output logic [31:0]           pc,
  output logic                  reg_we,
  output logic                  halted,
  output logic [2:0]            state,
  output logic [31:0]           retire_cnt
);

  state_t      state_q, state_d;
  logic [31:0] pc_q, ir_q, retire_q;
  logic        npc_ok, commit;

  assign npc_ok = pc_aligned(npc);
  assign commit = (state_q == S_WB) && npc_ok;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH:  if (mem.imem_valid) state_d = S_DECODE;
      S_DECODE: state_d = illegal ? S_HALT : S_EXEC;
      S_EXEC:   state_d = is_mem ? S_MEM : S_WB;
      S_MEM:    if (mem.dmem_ready) state_d = S_WB;
      // A misaligned target never retires; the core parks until reset.
      S_WB:     state_d = !npc_ok ? S_HALT : (run ? S_FETCH : S_IDLE);
      default:  state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      ir_q     <= NOP_INSN;
      retire_q <= RETIRE_INIT;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH && mem.imem_valid) ir_q <= mem.imem_rdata;
      if (commit) begin
        pc_q     <= npc;
        retire_q <= retire_q + 32'd1;
      end
    end
  end

  assign mem.imem_req  = (state_q == S_FETCH);
  assign mem.imem_addr = pc_q;
  assign mem.dmem_req  = (state_q == S_MEM);
  assign reg_we        = commit && wb_en;
  assign halted        = (state_q == S_HALT);
  assign state         = state_q;
  assign ir            = ir_q;
  assign pc            = pc_q;
  assign retire_cnt    = retire_q;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Multi-cycle control FSM that owns the architectural PC register and the instruction register. It drives instruction fetch, steps the instruction through decode, execute, memory and writeback, and commits the next-PC unit's npc result at writeback. It sits between the instruction/data memory ports and the decoder, next-PC unit and register file.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSN, 32'h0000_0013, IR reset value (addi x0,x0,0).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
run  in  1  level enable; sequencing proceeds while high
npc  in  32  next PC from next-PC unit (valid in WB)
is_mem  in  1  decoder: current instr is load/store
wb_en  in  1  decoder: current instr writes rd
illegal  in  1  decoder: unsupported encoding (valid in DECODE)
imem_req  out  1  fetch request
imem_addr  out  32  fetch address (= pc)
imem_valid  in  1  fetch data valid
imem_rdata  in  32  fetched instruction
dmem_req  out  1  data access request
dmem_ready  in  1  data access complete
ir  out  32  instruction register
pc  out  32  current PC
reg_we  out  1  register-file write strobe
halted  out  1  sticky halt flag
state  out  3  current FSM state (debug)
retire_cnt  out  32  retired-instruction counter

Behaviour:
- Reset (async, rst=1): state=IDLE, pc=RESET_PC, ir=NOP_INSN, retire_cnt=0, halted=0; all strobes 0.
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Codes 7+ go to HALT.
- IDLE: run=1 -> FETCH; else stay.
- FETCH: imem_req=1, imem_addr=pc held stable. On imem_valid: ir<=imem_rdata -> DECODE. Wait indefinitely otherwise.
- DECODE: 1 cycle. illegal=1 -> HALT; else EXEC.
- EXEC: 1 cycle. is_mem=1 -> MEM; else WB.
- MEM: dmem_req=1 until dmem_ready sampled high (same cycle permitted) -> WB.
- WB, npc[1:0]==0:
  - reg_we=wb_en for this cycle only.
  - pc<=npc; retire_cnt<=retire_cnt+1 (wraps FFFF_FFFF->0).
  - Next state: run=1 -> FETCH; run=0 -> IDLE.
- WB, npc[1:0]!=0 (misaligned target): reg_we=0, pc and retire_cnt unchanged -> HALT.
- HALT: halted=1, all strobes 0. Only rst exits HALT.
- run deassert mid-instruction: the current instruction completes through WB, then the FSM goes to IDLE. run is sampled only in IDLE and WB.
- Strobes are Moore outputs decoded from state; reg_we additionally ANDs wb_en and the alignment check.
- ir is held from FETCH completion until the next FETCH completion.
- Minimum latency, zero-wait memory:
  - non-memory instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - load/store: 5 cycles.
- Reset asserted mid-operation aborts immediately. A pending imem/dmem response is ignored because the FSM is in IDLE.

Decomposition:
- Shared define header (alongside the ALU code defines) holds the state encodings S_IDLE..S_HALT and the NOP_INSN constant.
- Single module; no sub-module is natural. The retire counter stays inline.

Test Plan:
- Reset then run=1, imem_valid every cycle, ir=0x00500093, wb_en=1, npc=pc+4 -> imem_addr=0x0 then 0x4; reg_we high exactly in cycle 4; retire_cnt=1.
- Fetch with imem_valid delayed 3 cycles -> imem_req held 4 cycles with imem_addr constant; ir updates only on the valid cycle.
- Load: is_mem=1, dmem_ready after 2 cycles -> dmem_req high 3 cycles; WB follows; total 7 cycles.
- Jump with npc=0x100 at WB -> next imem_addr=0x100. Then npc=0x102 -> halted=1, pc stays 0x100, reg_we=0, no further imem_req.
- illegal=1 in DECODE -> state=HALT next cycle; run toggling has no effect; rst returns pc=RESET_PC.
- run dropped during EXEC -> WB still commits, state goes to IDLE. retire_cnt preset to 0xFFFF_FFFF -> wraps to 0 on retire.
